// File: rtl/alu_seq_pkg.sv
// Shared encodings for the sequential Hack ALU: operation modes and FSM states.
package alu_seq_pkg;

  localparam logic [1:0] MODE_ALU = 2'b00;
  localparam logic [1:0] MODE_MUL = 2'b01;
  localparam logic [1:0] MODE_SHL = 2'b10;
  localparam logic [1:0] MODE_SAR = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_BUSY = 2'b01,
    S_DONE = 2'b10
  } state_t;

endpackage

// File: rtl/alu_seq_if.sv
// Request/response bundle between the decode stage (master) and alu_seq (slave).
interface alu_seq_if #(
  parameter int WIDTH = 16
) ();

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] x;
  logic [WIDTH-1:0] y;
  logic             zx;
  logic             nx;
  logic             zy;
  logic             ny;
  logic             f;
  logic             no;
  logic [1:0]       mode;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out;
  logic             zr;
  logic             ng;
  logic             carry;

  modport slave (
    input  in_valid, x, y, zx, nx, zy, ny, f, no, mode, out_ready,
    output in_ready, out_valid, out, zr, ng, carry
  );

  modport master (
    output in_valid, x, y, zx, nx, zy, ny, f, no, mode, out_ready,
    input  in_ready, out_valid, out, zr, ng, carry
  );

endinterface

// File: rtl/alu_seq_core.sv
// Combinational Hack ALU at generic width. The preprocessed operands are
// exported so the iterative datapath works on the same xp/yp.
module alu_core #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] i_x,
  input  logic [WIDTH-1:0] i_y,
  input  logic             i_zx,
  input  logic             i_nx,
  input  logic             i_zy,
  input  logic             i_ny,
  input  logic             i_f,
  input  logic             i_no,
  output logic [WIDTH-1:0] o_xp,
  output logic [WIDTH-1:0] o_yp,
  output logic [WIDTH-1:0] o_res,
  output logic             o_carry
);

  logic [WIDTH-1:0] w_xz;
  logic [WIDTH-1:0] w_yz;
  logic [WIDTH:0]   w_sum;
  logic [WIDTH-1:0] w_r;

  assign w_xz  = i_zx ? {WIDTH{1'b0}} : i_x;
  assign o_xp  = i_nx ? ~w_xz : w_xz;
  assign w_yz  = i_zy ? {WIDTH{1'b0}} : i_y;
  assign o_yp  = i_ny ? ~w_yz : w_yz;

  // Carry is taken from the raw sum, before the optional output inversion.
  assign w_sum   = {1'b0, o_xp} + {1'b0, o_yp};
  assign w_r     = i_f ? w_sum[WIDTH-1:0] : (o_xp & o_yp);
  assign o_res   = i_no ? ~w_r : w_r;
  assign o_carry = i_f & w_sum[WIDTH];

endmodule

// File: rtl/alu_seq.sv
// Handshaked Hack ALU with iterative multiply and bit-serial shifts.
// Result and flags are registered and held until the consumer takes them.
module alu_seq
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int SHW   = $clog2(WIDTH)
) (
  input logic       clock,
  input logic       reset_n,
  alu_seq_if.slave  bus
);

  localparam logic [SHW:0] CNT_MUL = (SHW+1)'(WIDTH);
  localparam logic [SHW:0] CNT_ONE = (SHW+1)'(1);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] r_opa;
  logic [WIDTH-1:0] r_opb;
  logic [SHW:0]     r_cnt;
  logic [1:0]       r_mode;
  logic [WIDTH-1:0] r_out;
  logic             r_zr;
  logic             r_ng;
  logic             r_carry;

  logic [WIDTH-1:0] w_xp;
  logic [WIDTH-1:0] w_yp;
  logic [WIDTH-1:0] w_res;
  logic             w_core_carry;
  logic             w_accept;
  logic [SHW-1:0]   w_shamt;
  logic             w_direct;
  logic [WIDTH-1:0] w_acc_step;
  logic [WIDTH-1:0] w_shl;
  logic [WIDTH-1:0] w_sar;
  logic             w_load_out;
  logic [WIDTH-1:0] w_out_val;
  logic             w_carry_val;

  alu_core #(.WIDTH(WIDTH)) u_core (
    .i_x     (bus.x),
    .i_y     (bus.y),
    .i_zx    (bus.zx),
    .i_nx    (bus.nx),
    .i_zy    (bus.zy),
    .i_ny    (bus.ny),
    .i_f     (bus.f),
    .i_no    (bus.no),
    .o_xp    (w_xp),
    .o_yp    (w_yp),
    .o_res   (w_res),
    .o_carry (w_core_carry)
  );

  // in_ready stays low while reset is asserted, then follows the IDLE state.
  assign bus.in_ready  = reset_n & (r_state == S_IDLE);
  assign bus.out_valid = (r_state == S_DONE);
  assign bus.out       = r_out;
  assign bus.zr        = r_zr;
  assign bus.ng        = r_ng;
  assign bus.carry     = r_carry;

  assign w_accept = bus.in_valid & bus.in_ready;
  assign w_shamt  = w_yp[SHW-1:0];
  // ALU ops and zero-length shifts finish in the accept cycle.
  assign w_direct = (bus.mode == MODE_ALU) ||
                    (bus.mode[1] && (w_shamt == {SHW{1'b0}}));

  assign w_acc_step = r_opb[0] ? (r_acc + r_opa) : r_acc;
  assign w_shl      = {r_opa[WIDTH-2:0], 1'b0};
  assign w_sar      = {r_opa[WIDTH-1], r_opa[WIDTH-1:1]};

  // State register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_state_nxt = w_direct ? S_DONE : S_BUSY;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_BUSY: begin
        if (r_cnt == CNT_ONE) begin
          w_state_nxt = S_DONE;
        end else begin
          w_state_nxt = S_BUSY;
        end
      end
      S_DONE: begin
        if (bus.out_ready) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_state_nxt = S_DONE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Selects when and what to write into the result/flag registers.
  always_comb begin
    w_load_out  = 1'b0;
    w_out_val   = r_out;
    w_carry_val = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_accept && (bus.mode == MODE_ALU)) begin
          w_load_out  = 1'b1;
          w_out_val   = w_res;
          w_carry_val = w_core_carry;
        end else if (w_accept && w_direct) begin
          w_load_out  = 1'b1;
          w_out_val   = w_xp;
        end else begin
          w_load_out  = 1'b0;
        end
      end
      S_BUSY: begin
        if (r_cnt == CNT_ONE) begin
          w_load_out = 1'b1;
          if (r_mode == MODE_MUL) begin
            w_out_val = w_acc_step;
          end else if (r_mode == MODE_SAR) begin
            w_out_val = w_sar;
          end else begin
            w_out_val = w_shl;
          end
        end else begin
          w_load_out = 1'b0;
        end
      end
      default: w_load_out = 1'b0;
    endcase
  end

  // Result/flag registers plus the iterative multiply/shift datapath.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_out   <= {WIDTH{1'b0}};
      r_zr    <= 1'b0;
      r_ng    <= 1'b0;
      r_carry <= 1'b0;
      r_acc   <= {WIDTH{1'b0}};
      r_opa   <= {WIDTH{1'b0}};
      r_opb   <= {WIDTH{1'b0}};
      r_cnt   <= {(SHW+1){1'b0}};
      r_mode  <= MODE_ALU;
    end else begin
      if (w_load_out) begin
        r_out   <= w_out_val;
        r_zr    <= (w_out_val == {WIDTH{1'b0}});
        r_ng    <= w_out_val[WIDTH-1];
        r_carry <= w_carry_val;
      end
      if ((r_state == S_IDLE) && w_accept) begin
        r_acc  <= {WIDTH{1'b0}};
        r_opa  <= w_xp;
        r_opb  <= w_yp;
        r_cnt  <= (bus.mode == MODE_MUL) ? CNT_MUL : {1'b0, w_shamt};
        r_mode <= bus.mode;
      end else if (r_state == S_BUSY) begin
        // The multiplicand shifts left exactly like an SHL operand.
        r_acc <= w_acc_step;
        r_opa <= (r_mode == MODE_SAR) ? w_sar : w_shl;
        r_opb <= {1'b0, r_opb[WIDTH-1:1]};
        r_cnt <= r_cnt - CNT_ONE;
      end
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq: vector table with a scoreboard queue,
// plus hand sequences for backpressure and asynchronous reset mid-multiply.
module tb_alu_seq;

  logic clock;
  logic reset_n;

  alu_seq_if #(.WIDTH(16)) bus ();

  alu_seq #(.WIDTH(16)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  typedef struct {
    logic [15:0] x;
    logic [15:0] y;
    logic [5:0]  ctl;   // {zx,nx,zy,ny,f,no}
    logic [1:0]  mode;
    logic [15:0] exp_out;
    logic        exp_carry;
    int          exp_lat;
    string       name;
  } vec_t;

  typedef struct {
    logic [15:0] out;
    logic        carry;
    int          lat;
  } exp_t;

  vec_t        vecs [14];
  exp_t        sb [$];
  int          total;
  int          bad;
  logic [15:0] last_out;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive_req(input logic [15:0] x, input logic [15:0] y,
                           input logic [5:0] ctl, input logic [1:0] mode);
    bus.x = x;
    bus.y = y;
    {bus.zx, bus.nx, bus.zy, bus.ny, bus.f, bus.no} = ctl;
    bus.mode = mode;
    bus.in_valid = 1'b1;
  endtask

  task automatic run_op(input vec_t v);
    exp_t e;
    int   lat;
    logic busy_ok;
    logic hold_ok;
    @(negedge clock);
    check({v.name, " in_ready idle"}, 32'(bus.in_ready), 32'd1);
    drive_req(v.x, v.y, v.ctl, v.mode);
    e.out = v.exp_out;
    e.carry = v.exp_carry;
    e.lat = v.exp_lat;
    sb.push_back(e);
    @(negedge clock);
    bus.in_valid = 1'b0;
    bus.x = 16'($urandom);
    bus.y = 16'($urandom);
    lat = 1;
    busy_ok = 1'b1;
    hold_ok = 1'b1;
    while (!bus.out_valid && lat < 200) begin
      if (bus.in_ready !== 1'b0) busy_ok = 1'b0;
      if (bus.out !== last_out) hold_ok = 1'b0;
      bus.in_valid = 1'($urandom_range(0, 1));
      bus.mode = 2'($urandom_range(0, 3));
      @(negedge clock);
      lat++;
    end
    bus.in_valid = 1'b0;
    e = sb.pop_front();
    check({v.name, " latency"}, 32'(lat), 32'(e.lat));
    if (e.lat > 1) begin
      check({v.name, " in_ready low in busy"}, 32'(busy_ok), 32'd1);
      check({v.name, " out held in busy"}, 32'(hold_ok), 32'd1);
    end
    check({v.name, " out"}, 32'(bus.out), 32'(e.out));
    check({v.name, " zr"}, 32'(bus.zr), 32'(e.out == 16'h0000));
    check({v.name, " ng"}, 32'(bus.ng), 32'(e.out[15]));
    check({v.name, " carry"}, 32'(bus.carry), 32'(e.carry));
    last_out = e.out;
    bus.out_ready = 1'b1;
    @(negedge clock);
    bus.out_ready = 1'b0;
    check({v.name, " out_valid drop"}, 32'(bus.out_valid), 32'd0);
    check({v.name, " in_ready back"}, 32'(bus.in_ready), 32'd1);
    check({v.name, " out kept"}, 32'(bus.out), 32'(e.out));
  endtask

  initial begin
    vec_t v;
    exp_t e;
    total = 0;
    bad = 0;
    last_out = 16'h0000;

    vecs[0]  = '{16'd5,    16'd3,    6'b000010, 2'b00, 16'd8,    1'b0, 1,  "add"};
    vecs[1]  = '{16'd5,    16'd3,    6'b010011, 2'b00, 16'd2,    1'b0, 1,  "sub5m3"};
    vecs[2]  = '{16'd3,    16'd5,    6'b010011, 2'b00, 16'hFFFE, 1'b1, 1,  "sub3m5"};
    vecs[3]  = '{16'hFFFF, 16'd1,    6'b000010, 2'b00, 16'h0000, 1'b1, 1,  "addwrap"};
    vecs[4]  = '{16'h0F0F, 16'h00FF, 6'b000000, 2'b00, 16'h000F, 1'b0, 1,  "and"};
    vecs[5]  = '{16'h1234, 16'h5555, 6'b001101, 2'b00, 16'hEDCB, 1'b0, 1,  "notx"};
    vecs[6]  = '{16'd300,  16'd300,  6'b000000, 2'b01, 16'h5F90, 1'b0, 17, "mul300"};
    vecs[7]  = '{16'd7,    16'd0,    6'b000111, 2'b01, 16'hFFF9, 1'b0, 17, "mulpre"};
    vecs[8]  = '{16'h8000, 16'd3,    6'b000000, 2'b11, 16'hF000, 1'b0, 4,  "sar3"};
    vecs[9]  = '{16'h1234, 16'd0,    6'b000000, 2'b10, 16'h1234, 1'b0, 1,  "shl0"};
    vecs[10] = '{16'h0001, 16'd15,   6'b000000, 2'b10, 16'h8000, 1'b0, 16, "shl15"};
    vecs[11] = '{16'h4000, 16'd2,    6'b000000, 2'b11, 16'h1000, 1'b0, 3,  "sar2pos"};
    vecs[12] = '{16'h00F0, 16'h0013, 6'b000000, 2'b10, 16'h0780, 1'b0, 4,  "shlmask"};
    vecs[13] = '{16'h8000, 16'h0000, 6'b000100, 2'b11, 16'hFFFF, 1'b0, 16, "sar15ny"};

    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    bus.x = 16'h0000;
    bus.y = 16'h0000;
    {bus.zx, bus.nx, bus.zy, bus.ny, bus.f, bus.no} = 6'b000000;
    bus.mode = 2'b00;

    // Power-on reset.
    reset_n = 1'b0;
    #3;
    check("reset out", 32'(bus.out), 32'd0);
    check("reset zr", 32'(bus.zr), 32'd0);
    check("reset out_valid", 32'(bus.out_valid), 32'd0);
    check("reset in_ready", 32'(bus.in_ready), 32'd0);
    #19;
    reset_n = 1'b1;

    for (int i = 0; i < 14; i++) begin
      run_op(vecs[i]);
    end

    // Backpressure: result must stay put while out_ready is low.
    @(negedge clock);
    drive_req(16'd5, 16'd3, 6'b000010, 2'b00);
    e.out = 16'd8;
    e.carry = 1'b0;
    e.lat = 1;
    sb.push_back(e);
    @(negedge clock);
    for (int i = 0; i < 5; i++) begin
      check("bp out_valid", 32'(bus.out_valid), 32'd1);
      check("bp out", 32'(bus.out), 32'd8);
      check("bp in_ready", 32'(bus.in_ready), 32'd0);
      drive_req(16'($urandom), 16'($urandom), 6'($urandom), 2'($urandom));
      @(negedge clock);
    end
    bus.in_valid = 1'b0;
    e = sb.pop_front();
    check("bp final out", 32'(bus.out), 32'(e.out));
    check("bp final zr", 32'(bus.zr), 32'(e.out == 16'h0000));
    bus.out_ready = 1'b1;
    @(negedge clock);
    bus.out_ready = 1'b0;
    check("bp handoff out_valid", 32'(bus.out_valid), 32'd0);
    last_out = e.out;
    run_op(vecs[2]);

    // Asynchronous reset in BUSY cycle 6 of a multiply.
    @(negedge clock);
    drive_req(16'd300, 16'd300, 6'b000000, 2'b01);
    e.out = 16'h5F90;
    e.carry = 1'b0;
    e.lat = 17;
    sb.push_back(e);
    @(negedge clock);
    bus.in_valid = 1'b0;
    repeat (5) @(negedge clock);
    check("pre-abort in_ready", 32'(bus.in_ready), 32'd0);
    #2;
    reset_n = 1'b0;
    #1;
    check("abort out", 32'(bus.out), 32'd0);
    check("abort ng", 32'(bus.ng), 32'd0);
    check("abort carry", 32'(bus.carry), 32'd0);
    check("abort out_valid", 32'(bus.out_valid), 32'd0);
    sb.delete();
    repeat (20) @(negedge clock);
    check("held reset out_valid", 32'(bus.out_valid), 32'd0);
    #3;
    reset_n = 1'b1;
    last_out = 16'h0000;
    v = vecs[1];
    run_op(v);
    v = vecs[6];
    run_op(v);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
